axi_lite_xbar_n: RTL and testbench
==================================

Name: axi_lite_xbar_n

Overview:
Parametrised 1-master to NUM_SLAVES AXI4-lite crossbar. It is the successor to the fixed mem/uart/clint router and sits between the core LSU/IFU arbiter and the memory-mapped slaves.
- Address map comes from base/mask parameters.
- Read and write paths are independent; each allows one outstanding transaction.
- The slave is locked from AR/AW acceptance until the R/B handshake completes.
- Unmapped addresses are answered internally with DECERR.

Parameters:
NUM_SLAVES, 3, number of downstream slaves (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SLV_BASE, {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000}, packed NUM_SLAVES*ADDR_W; slice i is at [i*ADDR_W +: ADDR_W]; defaults: 0=mem, 1=uart, 2=clint
SLV_MASK, {32'hffff_fff8, 32'hffff_ffff, 32'hf800_0000}, packed; slave i hits when (addr & MASK_i) == BASE_i

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
mst_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  upstream AW channel
mst_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  upstream W channel
mst_bresp/bvalid/bready  out/out/in  2/1/1  upstream B channel
mst_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  upstream AR channel
mst_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  upstream R channel
slv_awaddr/awvalid/awready  out/out/in  N*ADDR_W/N/N  downstream AW; N = NUM_SLAVES, slice i for slave i
slv_wdata/wstrb/wvalid/wready  out/out/out/in  N*DATA_W/N*DATA_W/8/N/N  downstream W
slv_bresp/bvalid/bready  in/in/out  N*2/N/N  downstream B
slv_araddr/arvalid/arready  out/out/in  N*ADDR_W/N/N  downstream AR
slv_rdata/rresp/rvalid/rready  in/in/out  N*DATA_W/N*2/N/N  downstream R
dec_err_rd/dec_err_wr  out/out  1/1  one-cycle pulse when an unmapped AR/AW is accepted

Behaviour:
- Decode: the lowest-index hitting slave wins; no hit selects the internal ERR target. Select is registered at acceptance and never recomputed.
- Non-selected slave slices: valid=0, ready=0, addr/data=0.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: mst_arready=1. On arvalid, latch addr and select, go to R_ADDR (or R_DATA if ERR); pulse dec_err_rd if ERR.
  - R_ADDR: slv_arvalid[sel]=1 with the latched addr until slv_arready[sel], then go to R_DATA. Minimum AR latency is 1 cycle (upstream accept to downstream valid).
  - R_DATA: mst_r* is routed combinationally from slave sel; slv_rready[sel]=mst_rready. On mst_rvalid&mst_rready, go to R_IDLE.
  - R_DATA with ERR: rvalid=1, rdata=0, rresp=DECERR.
- Write FSM, states W_IDLE, W_REQ, W_RESP, with flags aw_done and w_done:
  - W_IDLE: mst_awready=1. On awvalid, latch addr and select, clear both flags, go to W_REQ; pulse dec_err_wr if ERR.
  - W_REQ, AW: slv_awvalid[sel]=!aw_done; set aw_done on slv_awready[sel].
  - W_REQ, W: slv_wvalid[sel]=mst_wvalid&!w_done, mst_wready=slv_wready[sel]&!w_done; set w_done on the handshake.
  - W_REQ: W may precede, coincide with, or follow AW completion. Go to W_RESP when both flags are set, including when both set in the same cycle.
  - W_REQ with ERR: aw_done is set at entry; mst_wready=1 and the data is discarded.
  - W_RESP: B is routed from sel. With ERR: bvalid=1, bresp=DECERR. On mst_bvalid&mst_bready, go to W_IDLE.
- W data offered upstream in W_IDLE: mst_wready=0; it is held until W_REQ.
- Read and write may run concurrently to the same or different slaves; no ordering between them.
- A new AR/AW is never accepted while its path is busy (arready/awready=0 outside the idle state).
- Reset (rst_n low, any time, including mid-transaction):
  - Both FSMs go to idle and flags clear.
  - All mst_* and slv_* outputs are 0, and dec_err pulses are 0.
  - arready/awready are forced 0 while rst_n is low and rise in the first cycle after release.
- rresp/bresp from real slaves pass through unmodified (OKAY/SLVERR).

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - typedef enums rd_state_t and wr_state_t
- One sub-module, axi_lite_addr_decode (params NUM_SLAVES, ADDR_W, SLV_BASE, SLV_MASK; addr in, one-hot sel and hit out). It is instantiated twice, once for AR and once for AW.

Test Plan:
- AR 0x8000_0010, mem arready after 2 cycles, rdata=0xdeadbeef -> only slv_arvalid[0] is high; mst_rdata=0xdeadbeef, rresp=OKAY; arready low until R handshake.
- AW 0xa000_03f8 with W 3 cycles after AW, wdata=0x41, wstrb=0x1 -> only the uart slice is driven; W forwarded only in W_REQ; B OKAY returned once; awready re-asserted the next cycle.
- AR 0x9000_0000 (unmapped) -> dec_err_rd pulses 1 cycle; no slv_arvalid; rvalid with rdata=0, rresp=DECERR.
- AW 0x1000_0000 plus W, upstream bready held low 4 cycles -> W accepted and dropped; bresp=DECERR held stable until bready.
- Concurrent AR 0xa000_0048 (clint) and AW 0x8000_0000 (mem) in the same cycle, W in the same cycle as AW -> both complete independently; AW and W done together cause a direct transition to W_RESP.
- rst_n dropped while the read path is in R_DATA and the write path is in W_REQ -> all outputs 0 immediately; after release, arready=awready=1 and a fresh read to mem completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions for the crossbar: response codes and FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Address decoder: maps an address onto a one-hot slave select using base/mask pairs.
// Ports:
//   addr  in   ADDR_W      address to decode
//   sel   out  NUM_SLAVES  one-hot select (all zero when nothing hits)
//   hit   out  1           at least one slave matched
module axi_lite_addr_decode #(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hffff_fff8, 32'hffff_ffff, 32'hf800_0000}
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  // Scan from the top index down so the lowest-index match overwrites the others.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_xbar_n.sv
// 1-master to NUM_SLAVES AXI4-lite crossbar. Independent read and write paths, one
// outstanding transaction each; the chosen slave stays locked until R/B completes.
// Unmapped addresses are answered internally with DECERR.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mst_aw*/w*/b*/ar*/r* upstream AXI4-lite slave interface
//   slv_aw*/w*/b*/ar*/r* downstream AXI4-lite master interfaces, slice i for slave i
//   dec_err_rd/wr       one-cycle pulse after an unmapped AR/AW is accepted
module axi_lite_xbar_n
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'ha000_0048, 32'ha000_03f8, 32'h8000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hffff_fff8, 32'hffff_ffff, 32'hf800_0000}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // upstream
  input  logic [ADDR_W-1:0]              mst_awaddr,
  input  logic                           mst_awvalid,
  output logic                           mst_awready,
  input  logic [DATA_W-1:0]              mst_wdata,
  input  logic [DATA_W/8-1:0]            mst_wstrb,
  input  logic                           mst_wvalid,
  output logic                           mst_wready,
  output logic [1:0]                     mst_bresp,
  output logic                           mst_bvalid,
  input  logic                           mst_bready,
  input  logic [ADDR_W-1:0]              mst_araddr,
  input  logic                           mst_arvalid,
  output logic                           mst_arready,
  output logic [DATA_W-1:0]              mst_rdata,
  output logic [1:0]                     mst_rresp,
  output logic                           mst_rvalid,
  input  logic                           mst_rready,
  // downstream
  output logic [NUM_SLAVES*ADDR_W-1:0]   slv_awaddr,
  output logic [NUM_SLAVES-1:0]          slv_awvalid,
  input  logic [NUM_SLAVES-1:0]          slv_awready,
  output logic [NUM_SLAVES*DATA_W-1:0]   slv_wdata,
  output logic [NUM_SLAVES*DATA_W/8-1:0] slv_wstrb,
  output logic [NUM_SLAVES-1:0]          slv_wvalid,
  input  logic [NUM_SLAVES-1:0]          slv_wready,
  input  logic [NUM_SLAVES*2-1:0]        slv_bresp,
  input  logic [NUM_SLAVES-1:0]          slv_bvalid,
  output logic [NUM_SLAVES-1:0]          slv_bready,
  output logic [NUM_SLAVES*ADDR_W-1:0]   slv_araddr,
  output logic [NUM_SLAVES-1:0]          slv_arvalid,
  input  logic [NUM_SLAVES-1:0]          slv_arready,
  input  logic [NUM_SLAVES*DATA_W-1:0]   slv_rdata,
  input  logic [NUM_SLAVES*2-1:0]        slv_rresp,
  input  logic [NUM_SLAVES-1:0]          slv_rvalid,
  output logic [NUM_SLAVES-1:0]          slv_rready,
  output logic                           dec_err_rd,
  output logic                           dec_err_wr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  // Address decode for both channels
  logic [NUM_SLAVES-1:0] ar_sel_c, aw_sel_c;
  logic                  ar_hit_c, aw_hit_c;

  axi_lite_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_ar_dec (
    .addr(mst_araddr), .sel(ar_sel_c), .hit(ar_hit_c)
  );

  axi_lite_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_aw_dec (
    .addr(mst_awaddr), .sel(aw_sel_c), .hit(aw_hit_c)
  );

  // Read path state
  rd_state_t             rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [NUM_SLAVES-1:0] rd_sel_q, rd_sel_d;
  logic                  rd_err_q, rd_err_d;
  logic                  dec_err_rd_q, dec_err_rd_d;

  // Write path state
  wr_state_t             wr_state_q, wr_state_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [NUM_SLAVES-1:0] wr_sel_q, wr_sel_d;
  logic                  wr_err_q, wr_err_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  dec_err_wr_q, dec_err_wr_d;

  logic                  aw_hs_c, w_hs_c;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q   <= R_IDLE;
      rd_addr_q    <= '0;
      rd_sel_q     <= '0;
      rd_err_q     <= 1'b0;
      dec_err_rd_q <= 1'b0;
      wr_state_q   <= W_IDLE;
      wr_addr_q    <= '0;
      wr_sel_q     <= '0;
      wr_err_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      dec_err_wr_q <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_addr_q    <= rd_addr_d;
      rd_sel_q     <= rd_sel_d;
      rd_err_q     <= rd_err_d;
      dec_err_rd_q <= dec_err_rd_d;
      wr_state_q   <= wr_state_d;
      wr_addr_q    <= wr_addr_d;
      wr_sel_q     <= wr_sel_d;
      wr_err_q     <= wr_err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      dec_err_wr_q <= dec_err_wr_d;
    end
  end

  assign dec_err_rd = dec_err_rd_q;
  assign dec_err_wr = dec_err_wr_q;

  // Read FSM: next state and channel routing
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_addr_d    = rd_addr_q;
    rd_sel_d     = rd_sel_q;
    rd_err_d     = rd_err_q;
    dec_err_rd_d = 1'b0;
    mst_arready  = 1'b0;
    mst_rvalid   = 1'b0;
    mst_rdata    = '0;
    mst_rresp    = RESP_OKAY;
    slv_arvalid  = '0;
    slv_araddr   = '0;
    slv_rready   = '0;

    unique case (rd_state_q)
      R_IDLE: begin
        // Held low during reset so no request is seen as accepted
        mst_arready = rst_n;
        if (mst_arvalid) begin
          rd_addr_d    = mst_araddr;
          rd_sel_d     = ar_sel_c;
          rd_err_d     = !ar_hit_c;
          dec_err_rd_d = !ar_hit_c;
          rd_state_d   = ar_hit_c ? R_ADDR : R_DATA;
        end
      end
      R_ADDR: begin
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
          if (rd_sel_q[i]) begin
            slv_arvalid[i]                  = 1'b1;
            slv_araddr[i*ADDR_W +: ADDR_W] = rd_addr_q;
            if (slv_arready[i]) rd_state_d = R_DATA;
          end
        end
      end
      R_DATA: begin
        if (rd_err_q) begin
          mst_rvalid = 1'b1;
          mst_rresp  = RESP_DECERR;
        end else begin
          for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (rd_sel_q[i]) begin
              mst_rvalid    = slv_rvalid[i];
              mst_rdata     = slv_rdata[i*DATA_W +: DATA_W];
              mst_rresp     = slv_rresp[i*2 +: 2];
              slv_rready[i] = mst_rready;
            end
          end
        end
        if (mst_rvalid && mst_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM: AW and W complete independently in W_REQ, then B is routed back
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_addr_d    = wr_addr_q;
    wr_sel_d     = wr_sel_q;
    wr_err_d     = wr_err_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    dec_err_wr_d = 1'b0;
    aw_hs_c      = 1'b0;
    w_hs_c       = 1'b0;
    mst_awready  = 1'b0;
    mst_wready   = 1'b0;
    mst_bvalid   = 1'b0;
    mst_bresp    = RESP_OKAY;
    slv_awvalid  = '0;
    slv_awaddr   = '0;
    slv_wvalid   = '0;
    slv_wdata    = '0;
    slv_wstrb    = '0;
    slv_bready   = '0;

    unique case (wr_state_q)
      W_IDLE: begin
        mst_awready = rst_n;
        if (mst_awvalid) begin
          wr_addr_d    = mst_awaddr;
          wr_sel_d     = aw_sel_c;
          wr_err_d     = !aw_hit_c;
          // No downstream AW exists for the error target
          aw_done_d    = !aw_hit_c;
          w_done_d     = 1'b0;
          dec_err_wr_d = !aw_hit_c;
          wr_state_d   = W_REQ;
        end
      end
      W_REQ: begin
        if (wr_err_q) begin
          // Sink and discard the write data
          mst_wready = !w_done_q;
          w_hs_c     = mst_wvalid && !w_done_q;
        end
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
          if (wr_sel_q[i]) begin
            slv_awvalid[i] = !aw_done_q;
            if (!aw_done_q) slv_awaddr[i*ADDR_W +: ADDR_W] = wr_addr_q;
            aw_hs_c        = !aw_done_q && slv_awready[i];
            slv_wvalid[i]  = mst_wvalid && !w_done_q;
            if (!w_done_q) begin
              slv_wdata[i*DATA_W +: DATA_W] = mst_wdata;
              slv_wstrb[i*STRB_W +: STRB_W] = mst_wstrb;
            end
            mst_wready = slv_wready[i] && !w_done_q;
            w_hs_c     = mst_wvalid && slv_wready[i] && !w_done_q;
          end
        end
        aw_done_d = aw_done_q || aw_hs_c;
        w_done_d  = w_done_q || w_hs_c;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (wr_err_q) begin
          mst_bvalid = 1'b1;
          mst_bresp  = RESP_DECERR;
        end else begin
          for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (wr_sel_q[i]) begin
              mst_bvalid    = slv_bvalid[i];
              mst_bresp     = slv_bresp[i*2 +: 2];
              slv_bready[i] = mst_bready;
            end
          end
        end
        if (mst_bvalid && mst_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_xbar_n.sv
// Directed bench for axi_lite_xbar_n: table-driven read decode vectors plus
// hand-written write, concurrency and reset sequences.
module tb_axi_lite_xbar_n;
  import axi_lite_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int          ERR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0]   mst_awaddr;  logic mst_awvalid, mst_awready;
  logic [DW-1:0]   mst_wdata;   logic [SW-1:0] mst_wstrb; logic mst_wvalid, mst_wready;
  logic [1:0]      mst_bresp;   logic mst_bvalid, mst_bready;
  logic [AW-1:0]   mst_araddr;  logic mst_arvalid, mst_arready;
  logic [DW-1:0]   mst_rdata;   logic [1:0] mst_rresp; logic mst_rvalid, mst_rready;
  logic [N*AW-1:0] slv_awaddr;  logic [N-1:0] slv_awvalid, slv_awready;
  logic [N*DW-1:0] slv_wdata;   logic [N*SW-1:0] slv_wstrb; logic [N-1:0] slv_wvalid, slv_wready;
  logic [N*2-1:0]  slv_bresp;   logic [N-1:0] slv_bvalid, slv_bready;
  logic [N*AW-1:0] slv_araddr;  logic [N-1:0] slv_arvalid, slv_arready;
  logic [N*DW-1:0] slv_rdata;   logic [N*2-1:0] slv_rresp; logic [N-1:0] slv_rvalid, slv_rready;
  logic            dec_err_rd, dec_err_wr;

  axi_lite_xbar_n dut (
    .clk(clk), .rst_n(rst_n),
    .mst_awaddr(mst_awaddr), .mst_awvalid(mst_awvalid), .mst_awready(mst_awready),
    .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb), .mst_wvalid(mst_wvalid), .mst_wready(mst_wready),
    .mst_bresp(mst_bresp), .mst_bvalid(mst_bvalid), .mst_bready(mst_bready),
    .mst_araddr(mst_araddr), .mst_arvalid(mst_arvalid), .mst_arready(mst_arready),
    .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
    .slv_awaddr(slv_awaddr), .slv_awvalid(slv_awvalid), .slv_awready(slv_awready),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_wvalid(slv_wvalid), .slv_wready(slv_wready),
    .slv_bresp(slv_bresp), .slv_bvalid(slv_bvalid), .slv_bready(slv_bready),
    .slv_araddr(slv_araddr), .slv_arvalid(slv_arvalid), .slv_arready(slv_arready),
    .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
    .dec_err_rd(dec_err_rd), .dec_err_wr(dec_err_wr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mst_awaddr = '0; mst_awvalid = 1'b0; mst_wdata = '0; mst_wstrb = '0; mst_wvalid = 1'b0;
    mst_bready = 1'b0; mst_araddr = '0; mst_arvalid = 1'b0; mst_rready = 1'b0;
    slv_awready = '0; slv_wready = '0; slv_bresp = '0; slv_bvalid = '0;
    slv_arready = '0; slv_rdata = '0; slv_rresp = '0; slv_rvalid = '0;
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx < int'(N)) v[idx] = 1'b1;
    return v;
  endfunction

  // Single read; exp_slv == ERR means the address should be unmapped
  task automatic do_read(input string tag, input logic [AW-1:0] addr, input int exp_slv,
                         input int ar_lat, input logic [DW-1:0] data, input logic [1:0] resp);
    mst_araddr = addr; mst_arvalid = 1'b1; mst_rready = 1'b1;
    #1 chk({tag, "_arready_idle"}, 64'(mst_arready), 64'd1);
    cyc();
    mst_arvalid = 1'b0; mst_araddr = '0;
    #1;
    chk({tag, "_arready_busy"}, 64'(mst_arready), 64'd0);
    if (exp_slv == ERR) begin
      chk({tag, "_dec_err_rd"}, 64'(dec_err_rd), 64'd1);
      chk({tag, "_no_arvalid"}, 64'(slv_arvalid), 64'd0);
      chk({tag, "_err_r"}, {29'd0, mst_rvalid, mst_rresp, mst_rdata}, {29'd1, RESP_DECERR, 32'd0});
      cyc();
      #1;
      chk({tag, "_dec_err_once"}, 64'(dec_err_rd), 64'd0);
    end else begin
      chk({tag, "_dec_quiet"}, 64'(dec_err_rd), 64'd0);
      for (int k = 0; k < ar_lat; k++) begin
        chk({tag, "_arvalid_wait"}, 64'(slv_arvalid), 64'(onehot(exp_slv)));
        cyc();
        #1;
      end
      slv_arready[exp_slv] = 1'b1;
      #1;
      chk({tag, "_arvalid"}, 64'(slv_arvalid), 64'(onehot(exp_slv)));
      chk({tag, "_araddr"}, 64'(slv_araddr[exp_slv*AW +: AW]), 64'(addr));
      cyc();
      slv_arready = '0;
      #1;
      chk({tag, "_arvalid_drop"}, 64'(slv_arvalid), 64'd0);
      slv_rvalid[exp_slv] = 1'b1;
      slv_rdata[exp_slv*DW +: DW] = data;
      slv_rresp[exp_slv*2 +: 2] = resp;
      #1;
      chk({tag, "_r"}, {29'd0, mst_rvalid, mst_rresp, mst_rdata}, {29'd1, resp, data});
      chk({tag, "_rready_route"}, 64'(slv_rready), 64'(onehot(exp_slv)));
      cyc();
      slv_rvalid = '0; slv_rdata = '0; slv_rresp = '0;
      #1;
    end
    chk({tag, "_rvalid_done"}, 64'(mst_rvalid), 64'd0);
    chk({tag, "_arready_back"}, 64'(mst_arready), 64'd1);
    mst_rready = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            exp_slv;
    int            ar_lat;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rd_vec_t;

  rd_vec_t vecs [8];

  logic [18:0] all_out;
  assign all_out = {mst_awready, mst_wready, mst_bvalid, |mst_bresp, mst_arready, mst_rvalid,
                    |mst_rdata, |mst_rresp, |slv_awaddr, |slv_awvalid, |slv_wdata, |slv_wstrb,
                    |slv_wvalid, |slv_bready, |slv_araddr, |slv_arvalid, |slv_rready,
                    dec_err_rd, dec_err_wr};

  initial begin
    vecs[0] = '{32'h8000_0010, 0,   2, 32'hdead_beef, RESP_OKAY};
    vecs[1] = '{32'ha000_03f8, 1,   0, 32'h0000_0041, RESP_OKAY};
    vecs[2] = '{32'ha000_0048, 2,   1, 32'h1234_5678, RESP_SLVERR};
    vecs[3] = '{32'ha000_004c, 2,   0, 32'h0000_cafe, RESP_OKAY};
    vecs[4] = '{32'h9000_0000, ERR, 0, 32'h0,         RESP_OKAY};
    vecs[5] = '{32'ha000_03fc, ERR, 0, 32'h0,         RESP_OKAY};
    vecs[6] = '{32'h87ff_fffc, 0,   0, 32'h5555_aaaa, RESP_OKAY};
    vecs[7] = '{32'ha000_0050, ERR, 0, 32'h0,         RESP_OKAY};

    clear_inputs();
    rst_n = 1'b0;
    mst_arvalid = 1'b1; mst_awvalid = 1'b1;
    #1;
    chk("reset_outputs", 64'(all_out), 64'd0);
    cyc();
    chk("reset_ready_low", {62'd0, mst_arready, mst_awready}, 64'd0);
    clear_inputs();
    cyc();
    rst_n = 1'b1;
    #1;
    chk("release_ready", {62'd0, mst_arready, mst_awready}, 64'd3);

    for (int v = 0; v < 8; v++) begin
      do_read($sformatf("rd%0d", v), vecs[v].addr, vecs[v].exp_slv, vecs[v].ar_lat,
              vecs[v].data, vecs[v].resp);
    end

    // Write to uart, W arrives three cycles after AW
    cyc();
    mst_wvalid = 1'b1; mst_wdata = 32'h41; mst_wstrb = 4'h1; slv_wready = '1;
    #1;
    chk("w_idle_held", {62'd0, mst_wready, |slv_wvalid}, 64'd0);
    mst_wvalid = 1'b0;
    mst_awaddr = 32'ha000_03f8; mst_awvalid = 1'b1;
    #1 chk("w1_awready", 64'(mst_awready), 64'd1);
    cyc();
    mst_awvalid = 1'b0; mst_awaddr = '0; slv_awready[1] = 1'b1;
    #1;
    chk("w1_awvalid", 64'(slv_awvalid), 64'b010);
    chk("w1_awaddr", 64'(slv_awaddr[AW +: AW]), 64'ha000_03f8);
    chk("w1_awready_busy", 64'(mst_awready), 64'd0);
    cyc();
    slv_awready = '0;
    #1 chk("w1_aw_done", 64'(slv_awvalid), 64'd0);
    cyc();
    cyc();
    mst_wvalid = 1'b1;
    #1;
    chk("w1_wvalid", 64'(slv_wvalid), 64'b010);
    chk("w1_wdata", {28'd0, slv_wstrb[SW +: SW], slv_wdata[DW +: DW]}, {28'd0, 4'h1, 32'h41});
    chk("w1_wready", 64'(mst_wready), 64'd1);
    cyc();
    mst_wvalid = 1'b0; slv_wready = '0;
    slv_bvalid[1] = 1'b1; slv_bresp[3:2] = RESP_OKAY; mst_bready = 1'b1;
    #1;
    chk("w1_b", {61'd0, mst_bvalid, mst_bresp}, {61'd0, 1'b1, RESP_OKAY});
    chk("w1_bready_route", 64'(slv_bready), 64'b010);
    chk("w1_wvalid_off", 64'(slv_wvalid), 64'd0);
    cyc();
    slv_bvalid = '0;
    #1;
    chk("w1_done", {62'd0, mst_bvalid, mst_awready}, 64'd1);

    // Unmapped write, upstream stalls B for four cycles
    cyc();
    mst_awaddr = 32'h1000_0000; mst_awvalid = 1'b1; mst_wvalid = 1'b1; mst_wdata = 32'h77;
    mst_wstrb = 4'hf; mst_bready = 1'b0;
    #1 chk("w2_wready_idle", 64'(mst_wready), 64'd0);
    cyc();
    mst_awvalid = 1'b0;
    #1;
    chk("w2_dec_err_wr", 64'(dec_err_wr), 64'd1);
    chk("w2_no_slv", {61'd0, |slv_awvalid, |slv_wvalid, |slv_wdata}, 64'd0);
    chk("w2_wready", 64'(mst_wready), 64'd1);
    cyc();
    mst_wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("w2_b_stall", {60'd0, dec_err_wr, mst_bvalid, mst_bresp}, {60'd0, 1'b0, 1'b1, RESP_DECERR});
      cyc();
    end
    mst_bready = 1'b1;
    #1 chk("w2_b_accept", {61'd0, mst_bvalid, mst_bresp}, {61'd0, 1'b1, RESP_DECERR});
    cyc();
    mst_bready = 1'b0;
    #1 chk("w2_done", {62'd0, mst_bvalid, mst_awready}, 64'd1);

    // Concurrent read to clint and write to mem, AW and W together
    cyc();
    mst_araddr = 32'ha000_0048; mst_arvalid = 1'b1;
    mst_awaddr = 32'h8000_0000; mst_awvalid = 1'b1;
    mst_wvalid = 1'b1; mst_wdata = 32'hc0ff_ee00; mst_wstrb = 4'hc;
    #1 chk("c_ready", {61'd0, mst_arready, mst_awready, mst_wready}, 64'b110);
    cyc();
    mst_arvalid = 1'b0; mst_awvalid = 1'b0;
    slv_arready[2] = 1'b1; slv_awready[0] = 1'b1; slv_wready[0] = 1'b1;
    #1;
    chk("c_valids", {55'd0, slv_arvalid, slv_awvalid, slv_wvalid}, {55'd0, 3'b100, 3'b001, 3'b001});
    chk("c_wdata", {28'd0, slv_wstrb[3:0], slv_wdata[31:0]}, {28'd0, 4'hc, 32'hc0ff_ee00});
    chk("c_wready", 64'(mst_wready), 64'd1);
    cyc();
    mst_wvalid = 1'b0; slv_arready = '0; slv_awready = '0; slv_wready = '0;
    slv_bvalid[0] = 1'b1; slv_bresp[1:0] = RESP_SLVERR; mst_bready = 1'b1;
    slv_rvalid[2] = 1'b1; slv_rdata[2*DW +: DW] = 32'h0bad_f00d; mst_rready = 1'b1;
    #1;
    chk("c_direct_resp", {61'd0, mst_bvalid, mst_bresp}, {61'd0, 1'b1, RESP_SLVERR});
    chk("c_r", {30'd0, mst_rvalid, mst_rresp[0], mst_rdata}, {30'd0, 1'b1, 1'b0, 32'h0bad_f00d});
    chk("c_readies", {58'd0, slv_rready, slv_bready}, {58'd0, 3'b100, 3'b001});
    cyc();
    clear_inputs();
    #1 chk("c_done", {60'd0, mst_arready, mst_awready, mst_rvalid, mst_bvalid}, 64'b1100);

    // Reset while read is in R_DATA and write is in W_REQ
    cyc();
    mst_araddr = 32'h8000_0000; mst_arvalid = 1'b1;
    mst_awaddr = 32'ha000_03f8; mst_awvalid = 1'b1;
    cyc();
    mst_arvalid = 1'b0; mst_awvalid = 1'b0; slv_arready[0] = 1'b1;
    cyc();
    slv_arready = '0; mst_rready = 1'b1; mst_bready = 1'b1; mst_wvalid = 1'b1;
    slv_rvalid = '1; slv_bvalid = '1; slv_wready = '1;
    #1 chk("rst_busy", {58'd0, slv_rready, slv_awvalid}, {58'd0, 3'b001, 3'b010});
    rst_n = 1'b0;
    #1 chk("rst_mid_outputs", 64'(all_out), 64'd0);
    cyc();
    chk("rst_mid_hold", 64'(all_out), 64'd0);
    clear_inputs();
    rst_n = 1'b1;
    #1 chk("rst_release", {62'd0, mst_arready, mst_awready}, 64'd3);
    do_read("post_rst", 32'h8000_0010, 0, 1, 32'hfeed_0001, RESP_OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
